// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: pipeline-side hazard inputs and stall/flush/forward controls.
// Defining HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 4
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic              i_id_use_rs1, i_id_use_rs2, i_id_wren, i_id_long;
  logic [REG_AW-1:0] i_ex_rs1, i_ex_rs2;
  logic              i_mem_wren, i_wb_wren;
  logic [REG_AW-1:0] i_mem_rd, i_wb_rd;
  logic              i_lc_done;
  logic [REG_AW-1:0] i_lc_rd;
  logic              i_ex_redirect;
  logic              o_stall_pc, o_stall_if_id, o_stall_id_ex;
  logic              o_flush_if_id, o_flush_id_ex, o_flush_mux_pc;
  logic [1:0]        o_opa_sel, o_opb_sel;
  logic              o_issue;
  logic [NUM_REGS-1:0] o_busy;
  logic [CNT_W-1:0]  o_pending;
`ifdef HAZARD_PERF_EN
  logic [31:0]       o_stall_cycles, o_flush_count;
`endif
  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2, i_id_wren,
           i_id_long, i_ex_rs1, i_ex_rs2, i_mem_wren, i_wb_wren, i_mem_rd, i_wb_rd,
           i_lc_done, i_lc_rd, i_ex_redirect,
    input  o_stall_pc, o_stall_if_id, o_stall_id_ex, o_flush_if_id, o_flush_id_ex,
           o_flush_mux_pc, o_opa_sel, o_opb_sel, o_issue, o_busy, o_pending
`ifdef HAZARD_PERF_EN
    , input o_stall_cycles, o_flush_count
`endif
  );
  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2, i_id_wren,
           i_id_long, i_ex_rs1, i_ex_rs2, i_mem_wren, i_wb_wren, i_mem_rd, i_wb_rd,
           i_lc_done, i_lc_rd, i_ex_redirect,
    output o_stall_pc, o_stall_if_id, o_stall_id_ex, o_flush_if_id, o_flush_id_ex,
           o_flush_mux_pc, o_opa_sel, o_opb_sel, o_issue, o_busy, o_pending
`ifdef HAZARD_PERF_EN
    , output o_stall_cycles, o_flush_count
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard for long-latency writers plus forwarding and redirect flush.
// Defining HAZARD_PERF_EN adds saturating stall-cycle and flush counters.
module hazard_scoreboard #(
  parameter  int NUM_REGS    = 32,
  parameter  int MAX_PENDING = 4,
  localparam int REG_AW      = $clog2(NUM_REGS),
  localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input logic i_clk,
  input logic i_rst_n,
  hazard_scoreboard_if.slave bus
);
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_eff, lc_vec, set_vec;
  logic [CNT_W-1:0]    pending_q, pending_d, pending_after;
  logic                lc_ok, raw1, raw2, waw, full, hazard, stall, issue;
  // A completing write releases its register in the same cycle.
  assign lc_vec        = bus.i_lc_done ? (NUM_REGS'(1) << bus.i_lc_rd) : '0;
  assign busy_eff      = busy_q & ~lc_vec;
  assign lc_ok         = bus.i_lc_done & (pending_q != '0);
  assign pending_after = pending_q - CNT_W'(lc_ok);
  assign raw1   = bus.i_id_use_rs1 & busy_eff[bus.i_id_rs1] & (bus.i_id_rs1 != REG_AW'(0));
  assign raw2   = bus.i_id_use_rs2 & busy_eff[bus.i_id_rs2] & (bus.i_id_rs2 != REG_AW'(0));
  assign waw    = bus.i_id_wren & busy_eff[bus.i_id_rd] & (bus.i_id_rd != REG_AW'(0));
  assign full   = bus.i_id_long & (pending_after >= CNT_W'(MAX_PENDING));
  assign hazard = bus.i_id_valid & (raw1 | raw2 | waw | full);
  assign stall  = hazard & ~bus.i_ex_redirect;
  assign issue  = bus.i_id_valid & ~hazard & ~bus.i_ex_redirect;
  assign set_vec = (issue & bus.i_id_long & bus.i_id_wren & (bus.i_id_rd != REG_AW'(0)))
                 ? (NUM_REGS'(1) << bus.i_id_rd) : '0;
  assign busy_d    = busy_eff | set_vec;
  assign pending_d = pending_after + CNT_W'(issue & bus.i_id_long);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  assign bus.o_stall_pc     = stall;
  assign bus.o_stall_if_id  = stall;
  assign bus.o_stall_id_ex  = stall;
  assign bus.o_flush_if_id  = bus.i_ex_redirect;
  assign bus.o_flush_id_ex  = bus.i_ex_redirect;
  assign bus.o_flush_mux_pc = bus.i_ex_redirect;
  assign bus.o_issue        = issue;
  assign bus.o_busy         = busy_q;
  assign bus.o_pending      = pending_q;
  // MEM is younger than WB, so its value wins.
  assign bus.o_opa_sel = (bus.i_mem_wren & (bus.i_mem_rd != REG_AW'(0)) & (bus.i_mem_rd == bus.i_ex_rs1)) ? 2'b10
                       : (bus.i_wb_wren & (bus.i_wb_rd != REG_AW'(0)) & (bus.i_wb_rd == bus.i_ex_rs1)) ? 2'b01 : 2'b00;
  assign bus.o_opb_sel = (bus.i_mem_wren & (bus.i_mem_rd != REG_AW'(0)) & (bus.i_mem_rd == bus.i_ex_rs2)) ? 2'b10
                       : (bus.i_wb_wren & (bus.i_wb_rd != REG_AW'(0)) & (bus.i_wb_rd == bus.i_ex_rs2)) ? 2'b01 : 2'b00;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  assign stall_cycles_d = stall_cycles_q + 32'(stall & ~&stall_cycles_q);
  assign flush_count_d  = flush_count_q + 32'(bus.i_ex_redirect & ~&flush_count_q);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_flush_count  = flush_count_q;
`endif
  // Completion with nothing outstanding is a protocol error.
  a_lc_no_pending: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.i_lc_done && pending_q == '0));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plan scenarios plus randomized traffic against a queue-based reference model.
module tb_hazard_scoreboard;
  localparam int NR = 32;
  localparam int MP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bit mb[NR];
  int pend = 0;
  int q[$];
  int sc;
  hazard_scoreboard_if #(.NUM_REGS(NR), .MAX_PENDING(MP)) bus ();
  hazard_scoreboard #(.NUM_REGS(NR), .MAX_PENDING(MP)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit eff(int r);
    return mb[r] && !(bus.i_lc_done && int'(bus.i_lc_rd) == r);
  endfunction
  function automatic logic [1:0] fwd(int ex);
    if (bus.i_mem_wren && bus.i_mem_rd != 0 && int'(bus.i_mem_rd) == ex) return 2'b10;
    if (bus.i_wb_wren && bus.i_wb_rd != 0 && int'(bus.i_wb_rd) == ex) return 2'b01;
    return 2'b00;
  endfunction
  task automatic idle();
    {bus.i_id_valid, bus.i_id_use_rs1, bus.i_id_use_rs2, bus.i_id_wren, bus.i_id_long} = '0;
    {bus.i_id_rs1, bus.i_id_rs2, bus.i_id_rd, bus.i_ex_rs1, bus.i_ex_rs2} = '0;
    {bus.i_mem_wren, bus.i_wb_wren, bus.i_mem_rd, bus.i_wb_rd} = '0;
    {bus.i_lc_done, bus.i_lc_rd, bus.i_ex_redirect} = '0;
  endtask
  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit w, input bit l);
    bus.i_id_valid = v; bus.i_id_rs1 = 5'(rs1); bus.i_id_rs2 = 5'(rs2); bus.i_id_rd = 5'(rd);
    bus.i_id_use_rs1 = u1; bus.i_id_use_rs2 = u2; bus.i_id_wren = w; bus.i_id_long = l;
  endtask
  task automatic complete(input int rd);
    bus.i_lc_done = 1'b1;
    bus.i_lc_rd = 5'(rd);
  endtask
  // Inputs are set at the falling edge; outputs are checked 1 time unit later, model steps at the rising edge.
  task automatic step();
    bit haz, stl, iss;
    int pa;
    logic [NR-1:0] bv;
    #1;
    pa = pend - ((bus.i_lc_done && pend > 0) ? 1 : 0);
    haz = bus.i_id_valid && ((bus.i_id_use_rs1 && bus.i_id_rs1 != 0 && eff(int'(bus.i_id_rs1))) ||
                             (bus.i_id_use_rs2 && bus.i_id_rs2 != 0 && eff(int'(bus.i_id_rs2))) ||
                             (bus.i_id_wren && bus.i_id_rd != 0 && eff(int'(bus.i_id_rd))) ||
                             (bus.i_id_long && pa >= MP));
    stl = haz && !bus.i_ex_redirect;
    iss = bus.i_id_valid && !haz && !bus.i_ex_redirect;
    for (int r = 0; r < NR; r++) bv[r] = mb[r];
    check("stall_pc", 64'(bus.o_stall_pc), 64'(stl));
    check("stall_if_id", 64'(bus.o_stall_if_id), 64'(stl));
    check("stall_id_ex", 64'(bus.o_stall_id_ex), 64'(stl));
    check("flush_if_id", 64'(bus.o_flush_if_id), 64'(bus.i_ex_redirect));
    check("flush_id_ex", 64'(bus.o_flush_id_ex), 64'(bus.i_ex_redirect));
    check("flush_mux_pc", 64'(bus.o_flush_mux_pc), 64'(bus.i_ex_redirect));
    check("issue", 64'(bus.o_issue), 64'(iss));
    check("opa_sel", 64'(bus.o_opa_sel), 64'(fwd(int'(bus.i_ex_rs1))));
    check("opb_sel", 64'(bus.o_opb_sel), 64'(fwd(int'(bus.i_ex_rs2))));
    check("busy", 64'(bus.o_busy), 64'(bv));
    check("pending", 64'(bus.o_pending), 64'(pend));
    sc += bus.o_stall_pc ? 1 : 0;
    @(posedge clk);
    if (bus.i_lc_done && pend > 0) begin
      mb[bus.i_lc_rd] = 1'b0;
      pend--;
      for (int k = 0; k < q.size(); k++)
        if (q[k] == int'(bus.i_lc_rd)) begin
          q.delete(k);
          break;
        end
    end
    if (iss && bus.i_id_long) begin
      pend++;
      q.push_back(int'(bus.i_id_rd));
      if (bus.i_id_wren && bus.i_id_rd != 0) mb[bus.i_id_rd] = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 64) begin
      idle();
      complete(q[0]);
      step();
      guard++;
    end
    idle();
    check("drained", 64'(q.size()), 64'd0);
  endtask
  initial begin
    idle();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_pending", 64'(bus.o_pending), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    set_id(1, 0, 0, 2, 0, 0, 1, 1); step();
    set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
    idle(); step();
    check("pre_rst_busy", 64'(bus.o_busy), 64'h24);
    check("pre_rst_pending", 64'(bus.o_pending), 64'd2);
    set_id(1, 5, 0, 0, 1, 0, 0, 0);
    #1 check("pre_rst_stall", 64'(bus.o_stall_pc), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.o_busy), 64'd0);
    check("async_rst_pending", 64'(bus.o_pending), 64'd0);
    check("async_rst_stall", 64'({bus.o_stall_pc, bus.o_stall_if_id, bus.o_stall_id_ex}), 64'd0);
    foreach (mb[r]) mb[r] = 1'b0;
    pend = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
    sc = 0;
    set_id(1, 5, 0, 0, 1, 0, 0, 0);
    repeat (3) step();
    complete(5);
    #1 check("bypass_issue", 64'(bus.o_issue), 64'd1);
    step();
    check("stall_len", 64'(sc), 64'd3);
    idle();
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, r, 0, 0, 1, 1);
      step();
    end
    set_id(1, 0, 0, 6, 0, 0, 1, 1);
    #1 check("full_stall", 64'(bus.o_stall_pc), 64'd1);
    step();
    complete(1);
    #1 check("full_release", 64'(bus.o_issue), 64'd1);
    step();
    idle(); step();
    check("full_pending", 64'(bus.o_pending), 64'd4);
    drain();
    set_id(1, 0, 0, 7, 0, 0, 1, 1); step();
    set_id(1, 0, 0, 7, 0, 0, 1, 1);
    complete(7);
    step();
    idle(); step();
    check("setwin_busy7", 64'(bus.o_busy[7]), 64'd1);
    check("setwin_pending", 64'(bus.o_pending), 64'd1);
    drain();
    set_id(1, 0, 0, 8, 0, 0, 1, 1); step();
    set_id(1, 8, 0, 0, 1, 0, 0, 0);
    bus.i_ex_redirect = 1'b1;
    #1 check("redir_issue", 64'(bus.o_issue), 64'd0);
    step();
    idle(); step();
    check("redir_busy", 64'(bus.o_busy), 64'h100);
    drain();
    bus.i_mem_wren = 1'b1; bus.i_mem_rd = 5'd9;
    bus.i_wb_wren = 1'b1; bus.i_wb_rd = 5'd9;
    bus.i_ex_rs1 = 5'd9; bus.i_ex_rs2 = 5'd0;
    #1 check("fwd_mem", 64'(bus.o_opa_sel), 64'd2);
    step();
    bus.i_mem_rd = 5'd0;
    #1 check("fwd_wb", 64'(bus.o_opa_sel), 64'd1);
    check("fwd_x0", 64'(bus.o_opb_sel), 64'd0);
    step();
    for (int n = 0; n < 3000; n++) begin
      bit l;
      l = ($urandom % 3) == 0;
      set_id(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom), 1'($urandom), l | 1'($urandom), l);
      bus.i_ex_rs1 = 5'($urandom_range(0, 7));
      bus.i_ex_rs2 = 5'($urandom_range(0, 7));
      bus.i_mem_wren = 1'($urandom); bus.i_mem_rd = 5'($urandom_range(0, 7));
      bus.i_wb_wren = 1'($urandom); bus.i_wb_rd = 5'($urandom_range(0, 7));
      bus.i_ex_redirect = ($urandom % 10) == 0;
      if (q.size() > 0 && ($urandom % 3) == 0) complete(q[$urandom_range(0, q.size() - 1)]);
      else begin
        bus.i_lc_done = 1'b0;
        bus.i_lc_rd = 5'($urandom_range(0, 7));
      end
      step();
    end
    drain();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
